// File: rtl/key_expander.sv
// AES key expansion: produces one 32-bit schedule word per clock after start.
// Works for AES-128, AES-192 and AES-256 (Nk = 4, 6, 8).
module key_expander #(
    parameter int Nk = 4,
    parameter int Nr = Nk + 6
) (
    input  logic                    clks,
    input  logic                    reset,
    input  logic                    start,
    input  logic [0:Nk*32-1]        key,
    output logic                    busy,
    output logic                    done,
    output logic                    keys_valid,
    output logic [0:128*(Nr+1)-1]   keys
);

    localparam int NW = 4 * (Nr + 1);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] EXPAND = 2'd1;
    localparam logic [1:0] DONE   = 2'd2;

    localparam logic [5:0] NK_W    = 6'(Nk);
    localparam logic [5:0] LAST_W  = 6'(NW - 1);
    localparam logic [2:0] NK_LAST = 3'(Nk - 1);

    localparam logic [0:2047] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76,
        128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115,
        128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84,
        128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8,
        128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973,
        128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479,
        128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
        128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df,
        128'h8ca1890dbfe6426841992d0fb054bb16
    };

    function automatic logic [7:0] sbox(input logic [7:0] b);
        return SBOX[{b, 3'b000} +: 8];
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [31:0] rot_word(input logic [31:0] w);
        return {w[23:0], w[31:24]};
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    logic [1:0]  state_q, state_d;
    logic [5:0]  i_q, i_d;
    logic [2:0]  imod_q, imod_d;
    logic [7:0]  rcon_q, rcon_d;
    logic        done_q, done_d;
    logic        valid_q, valid_d;
    logic [31:0] w_q [NW];
    logic [31:0] w_d [NW];
    logic [31:0] temp;

    // One schedule word per EXPAND cycle; imod tracks i mod Nk without a divider.
    always_comb begin
        state_d = state_q;
        i_d     = i_q;
        imod_d  = imod_q;
        rcon_d  = rcon_q;
        done_d  = 1'b0;
        valid_d = valid_q;
        w_d     = w_q;
        temp    = '0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    for (int j = 0; j < Nk; j++) begin
                        w_d[j] = key[32*j +: 32];
                    end
                    i_d     = NK_W;
                    imod_d  = 3'd0;
                    rcon_d  = 8'h01;
                    valid_d = 1'b0;
                    state_d = EXPAND;
                end
            end
            EXPAND: begin
                temp = w_q[i_q - 6'd1];
                if (imod_q == 3'd0) begin
                    temp   = sub_word(rot_word(temp)) ^ {rcon_q, 24'h000000};
                    rcon_d = xtime(rcon_q);
                end else if (Nk == 8 && imod_q == 3'd4) begin
                    temp = sub_word(temp);
                end
                w_d[i_q] = w_q[i_q - NK_W] ^ temp;
                i_d      = i_q + 6'd1;
                imod_d   = (imod_q == NK_LAST) ? 3'd0 : imod_q + 3'd1;
                if (i_q == LAST_W) begin
                    done_d  = 1'b1;
                    valid_d = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clks) begin
        if (reset) begin
            state_q <= IDLE;
            i_q     <= 6'd0;
            imod_q  <= 3'd0;
            rcon_q  <= 8'h01;
            done_q  <= 1'b0;
            valid_q <= 1'b0;
            w_q     <= '{default: '0};
        end else begin
            state_q <= state_d;
            i_q     <= i_d;
            imod_q  <= imod_d;
            rcon_q  <= rcon_d;
            done_q  <= done_d;
            valid_q <= valid_d;
            w_q     <= w_d;
        end
    end

    assign busy       = (state_q == EXPAND);
    assign done       = done_q;
    assign keys_valid = valid_q;

    always_comb begin
        keys = '0;
        for (int j = 0; j < NW; j++) begin
            keys[32*j +: 32] = w_q[j];
        end
    end

endmodule

// File: tb/tb_key_expander.sv
// Scoreboard bench for key_expander at Nk = 4, 6 and 8 using FIPS-197 vectors.
// Stimulus queues expected latency and words; a negedge monitor checks them on done.
module tb_key_expander;

    logic clks = 1'b0;
    always #5 clks = ~clks;

    logic           reset;
    logic           start4, start6, start8;
    logic [0:127]   key4;
    logic [0:191]   key6;
    logic [0:255]   key8;
    logic           busy4, busy6, busy8;
    logic           done4, done6, done8;
    logic           valid4, valid6, valid8;
    logic [0:1407]  keys4;
    logic [0:1663]  keys6;
    logic [0:1919]  keys8;

    key_expander #(.Nk(4)) dut4 (
        .clks(clks), .reset(reset), .start(start4), .key(key4),
        .busy(busy4), .done(done4), .keys_valid(valid4), .keys(keys4)
    );
    key_expander #(.Nk(6)) dut6 (
        .clks(clks), .reset(reset), .start(start6), .key(key6),
        .busy(busy6), .done(done6), .keys_valid(valid6), .keys(keys6)
    );
    key_expander #(.Nk(8)) dut8 (
        .clks(clks), .reset(reset), .start(start8), .key(key8),
        .busy(busy8), .done(done8), .keys_valid(valid8), .keys(keys8)
    );

    typedef struct packed { int dut; int acc; int lat; int nchk; } txn_t;
    typedef struct packed { int dut; int idx; logic [31:0] val; } wchk_t;

    txn_t  txn_q[$];
    wchk_t chk_q[$];
    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    logic  prev_done [3] = '{1'b0, 1'b0, 1'b0};

    localparam logic [0:255] KA = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
    localparam logic [0:255] KB = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
    localparam logic [0:255] KC = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
    localparam logic [0:255] KD = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

    always @(posedge clks) cyc <= cyc + 1;

    task automatic cmp(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Called on every negedge per DUT; on a done pulse it retires one queued transaction.
    task automatic checkOutput(input int k, input logic d, input logic kv, input logic [0:1919] kw);
        int    t;
        txn_t  x;
        wchk_t c;
        if (d !== 1'b1) begin
            prev_done[k] = 1'b0;
            return;
        end
        cmp($sformatf("dut%0d_done_one_cycle", k), 128'(prev_done[k]), 128'd0);
        prev_done[k] = 1'b1;
        t = -1;
        for (int j = 0; j < txn_q.size(); j++) begin
            if (t < 0 && txn_q[j].dut == k) t = j;
        end
        checks++;
        if (t < 0) begin
            failures++;
            $display("[TB] FAIL dut%0d_unexpected_done: got done=1 expected no done", k);
            return;
        end
        x = txn_q[t];
        txn_q.delete(t);
        cmp($sformatf("dut%0d_latency", k), 128'(cyc - x.acc), 128'(x.lat));
        cmp($sformatf("dut%0d_valid_at_done", k), 128'(kv), 128'd1);
        for (int n = 0; n < x.nchk; n++) begin
            t = -1;
            for (int j = 0; j < chk_q.size(); j++) begin
                if (t < 0 && chk_q[j].dut == k) t = j;
            end
            if (t >= 0) begin
                c = chk_q[t];
                chk_q.delete(t);
                cmp($sformatf("dut%0d_W%0d", k, c.idx), 128'(kw[32*c.idx +: 32]), 128'(c.val));
            end
        end
    endtask

    // Monitor: keys buses are left-aligned into one width so word offsets stay the same.
    always @(negedge clks) begin
        checkOutput(0, done4, valid4, {keys4, 512'b0});
        checkOutput(1, done6, valid6, {keys6, 256'b0});
        checkOutput(2, done8, valid8, keys8);
    end

    task automatic addWord(input int k, input int idx, input logic [31:0] v);
        chk_q.push_back(wchk_t'{dut: k, idx: idx, val: v});
    endtask

    task automatic applyStimulus(input int k, input logic [0:255] kv, input bit exp_done,
                                 input int lat, input int nchk);
        case (k)
            0: begin key4 = kv[0:127]; start4 = 1'b1; end
            1: begin key6 = kv[0:191]; start6 = 1'b1; end
            default: begin key8 = kv; start8 = 1'b1; end
        endcase
        if (exp_done) txn_q.push_back(txn_t'{dut: k, acc: cyc + 1, lat: lat, nchk: nchk});
        @(negedge clks);
        start4 = 1'b0;
        start6 = 1'b0;
        start8 = 1'b0;
    endtask

    task automatic waitDone(input int k, input int max_cyc);
        bit seen = 1'b0;
        for (int n = 0; n < max_cyc && !seen; n++) begin
            @(negedge clks);
            seen = (k == 0) ? done4 : (k == 1) ? done6 : done8;
        end
        checks++;
        if (!seen) begin
            failures++;
            $display("[TB] FAIL dut%0d_done_timeout: got no done expected done within %0d cycles", k, max_cyc);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no end of test expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset  = 1'b1;
        start4 = 1'b0; start6 = 1'b0; start8 = 1'b0;
        key4   = '0;   key6   = '0;   key8   = '0;
        repeat (2) @(negedge clks);
        cmp("rst_busy4", 128'(busy4), 128'd0);
        cmp("rst_done4", 128'(done4), 128'd0);
        cmp("rst_valid4", 128'(valid4), 128'd0);
        cmp("rst_keys4_zero", 128'(keys4 == '0), 128'd1);
        cmp("rst_keys8_zero", 128'(keys8 == '0), 128'd1);
        reset = 1'b0;
        repeat (3) @(negedge clks);
        cmp("idle_hold_busy4", 128'(busy4), 128'd0);
        cmp("idle_hold_done4", 128'(done4), 128'd0);

        // AES-128 key 000102..0f
        addWord(0, 0, 32'h00010203);  addWord(0, 3, 32'h0c0d0e0f);
        addWord(0, 4, 32'hd6aa74fd);  addWord(0, 5, 32'hd2af72fa);
        addWord(0, 6, 32'hdaa678f1);  addWord(0, 7, 32'hd6ab76fe);
        addWord(0, 40, 32'h13111d7f); addWord(0, 41, 32'he3944a17);
        addWord(0, 42, 32'hf307a78b); addWord(0, 43, 32'h4d2b30c5);
        applyStimulus(0, KA, 1'b1, 40, 10);
        cmp("accept_busy4", 128'(busy4), 128'd1);
        cmp("accept_valid4", 128'(valid4), 128'd0);
        waitDone(0, 60);
        key4 = KB[0:127];
        start4 = 1'b1;
        @(negedge clks);
        start4 = 1'b0;
        cmp("start_in_done_ignored_busy4", 128'(busy4), 128'd0);
        cmp("after_done_valid4", 128'(valid4), 128'd1);
        cmp("done_dropped4", 128'(done4), 128'd0);
        repeat (5) @(negedge clks);
        cmp("hold_valid4", 128'(valid4), 128'd1);
        cmp("hold_round_key10", 128'(keys4[1280 +: 128]), 128'h13111d7fe3944a17f307a78b4d2b30c5);

        // AES-128 key 2b7e..; a second start with another key mid-expansion must be ignored
        addWord(0, 4, 32'ha0fafe17);  addWord(0, 7, 32'h2a6c7605);
        addWord(0, 40, 32'hd014f9a8); addWord(0, 41, 32'hc9ee2589);
        addWord(0, 42, 32'he13f0cc8); addWord(0, 43, 32'hb6630ca6);
        applyStimulus(0, KB, 1'b1, 40, 6);
        cmp("restart_drops_valid4", 128'(valid4), 128'd0);
        cmp("restart_busy4", 128'(busy4), 128'd1);
        repeat (10) @(negedge clks);
        key4 = KA[0:127];
        start4 = 1'b1;
        @(negedge clks);
        start4 = 1'b0;
        waitDone(0, 60);
        repeat (50) @(negedge clks);
        cmp("after_ignored_start_busy4", 128'(busy4), 128'd0);

        // AES-192
        addWord(1, 0, 32'h8e73b0f7); addWord(1, 6, 32'hfe0c91f7); addWord(1, 51, 32'h01002202);
        applyStimulus(1, KC, 1'b1, 46, 3);
        cmp("accept_busy6", 128'(busy6), 128'd1);
        waitDone(1, 70);

        // AES-256
        addWord(2, 0, 32'h603deb10); addWord(2, 8, 32'h9ba35411); addWord(2, 59, 32'h706c631e);
        applyStimulus(2, KD, 1'b1, 52, 3);
        cmp("accept_busy8", 128'(busy8), 128'd1);
        waitDone(2, 80);
        @(negedge clks);

        // Reset during expansion aborts it; the next start must still be exact
        applyStimulus(0, KA, 1'b0, 0, 0);
        repeat (19) @(negedge clks);
        cmp("pre_abort_busy4", 128'(busy4), 128'd1);
        reset = 1'b1;
        @(negedge clks);
        cmp("abort_busy4", 128'(busy4), 128'd0);
        cmp("abort_valid4", 128'(valid4), 128'd0);
        cmp("abort_done4", 128'(done4), 128'd0);
        cmp("abort_keys4_zero", 128'(keys4 == '0), 128'd1);
        reset = 1'b0;
        @(negedge clks);
        addWord(0, 4, 32'hd6aa74fd);  addWord(0, 5, 32'hd2af72fa);
        addWord(0, 6, 32'hdaa678f1);  addWord(0, 7, 32'hd6ab76fe);
        addWord(0, 43, 32'h4d2b30c5);
        applyStimulus(0, KA, 1'b1, 40, 5);
        waitDone(0, 60);

        repeat (5) @(negedge clks);
        checks++;
        if (txn_q.size() != 0 || chk_q.size() != 0) begin
            failures++;
            $display("[TB] FAIL scoreboard_drain: got %0d txns %0d words pending expected 0 0",
                     txn_q.size(), chk_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
